// File: rtl/dir_input_ctrl.sv
// dir_input_ctrl: debounced 4-way direction input with a periodic movement strobe.
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset
//   btn_raw    [3:0] asynchronous raw buttons, active high {L,U,R,D}
//   enable     gates btn; debounce, dir and the tick counter keep running
//   btn        [3:0] one-cycle copy of dir after each move_tick, else 0
//   dir        [3:0] latched direction, one-hot or 0
//   move_tick  strobe in the last cycle of every MOVE_PERIOD window
//
// Bit order everywhere: bit3 = L, bit2 = U, bit1 = R, bit0 = D.

// One button lane: 2-flop synchronizer followed by a run-length debouncer.
module dir_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample agreeing with the accepted level restarts the run, so
      // only DEBOUNCE_CYCLES consecutive disagreeing samples flip it.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module dir_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_PERIOD     = 500000,
  parameter bit HOLD_DIR        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       enable,
  output logic [3:0] btn,
  output logic [3:0] dir,
  output logic       move_tick
);
  localparam int TW = $clog2(MOVE_PERIOD);
  localparam logic [TW-1:0] TICK_MAX = TW'(MOVE_PERIOD - 1);

  logic [3:0]    db, db_q;
  logic [3:0]    rise, fall, rise_pick;
  logic [TW-1:0] tcnt;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dir_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (db[i])
    );
  end

  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

  // Fixed priority L > U > R > D for edges landing in the same cycle.
  always_comb begin
    rise_pick = 4'b0000;
    if      (rise[3]) rise_pick = 4'b1000;
    else if (rise[2]) rise_pick = 4'b0100;
    else if (rise[1]) rise_pick = 4'b0010;
    else if (rise[0]) rise_pick = 4'b0001;
  end

  assign move_tick = (tcnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= 4'b0000;
      tcnt <= '0;
      btn  <= 4'b0000;
      dir  <= 4'b0000;
    end else begin
      db_q <= db;
      tcnt <= move_tick ? '0 : tcnt + TW'(1);
      // dir is sampled before its own update, so a change coinciding with
      // the tick only shows up on the following strobe.
      btn  <= move_tick ? (dir & {4{enable}}) : 4'b0000;
      if (rise != 4'b0000)
        dir <= rise_pick;
      else if (!HOLD_DIR && ((fall & dir) != 4'b0000))
        dir <= 4'b0000;
    end
  end
endmodule
